run_detect_ctrl: RTL and testbench

- Frame-based controller around a consecutive-ones detector.
- On `start`, latches a programmable run-length threshold and frame length, then consumes `frame_len` qualified serial bits.
- Pulses `outp` on every completed run of `run_len` consecutive 1s and counts hits.
- Signals frame completion with a `done`/`ack` handshake, so the serial detection path can be sequenced frame by frame from a host FSM.

---
 rtl/run_detect_ctrl.sv | 119 +++++++++++
 tb/tb_run_detect_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/run_detect_ctrl.sv
// rtl/run_detect_ctrl.sv - frame-sequenced consecutive-ones run detector with done/ack handshake
module run_detect_ctrl #(
    parameter int CNT_W   = 4,
    parameter int FRAME_W = 8,
    parameter int HIT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   run_len,
    input  logic [FRAME_W-1:0] frame_len,
    input  logic               inp,
    input  logic               in_valid,
    input  logic               ack,
    output logic               busy,
    output logic               outp,
    output logic [HIT_W-1:0]   hit_cnt,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   thr_q, thr_d;
    logic [FRAME_W-1:0] flen_q, flen_d;
    logic [CNT_W-1:0]   run_q, run_d;
    logic [FRAME_W-1:0] bit_q, bit_d;
    logic [HIT_W-1:0]   hit_q, hit_d;
    logic               outp_q, outp_d;

    logic [CNT_W-1:0]   run_nxt;
    logic [FRAME_W-1:0] bit_nxt;

    assign run_nxt = run_q + CNT_W'(1);
    assign bit_nxt = bit_q + FRAME_W'(1);

    // State register and all registered datapath state; busy/done decode from state only
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            thr_q   <= '0;
            flen_q  <= '0;
            run_q   <= '0;
            bit_q   <= '0;
            hit_q   <= '0;
            outp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            thr_q   <= thr_d;
            flen_q  <= flen_d;
            run_q   <= run_d;
            bit_q   <= bit_d;
            hit_q   <= hit_d;
            outp_q  <= outp_d;
        end
    end

    // Next-state and datapath update; run restarts after each hit so detection never overlaps
    always_comb begin
        state_d = state_q;
        thr_d   = thr_q;
        flen_d  = flen_q;
        run_d   = run_q;
        bit_d   = bit_q;
        hit_d   = hit_q;
        outp_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    thr_d   = (run_len == '0) ? CNT_W'(1) : run_len;
                    flen_d  = frame_len;
                    run_d   = '0;
                    bit_d   = '0;
                    hit_d   = '0;
                    state_d = (frame_len == '0) ? S_WAIT : S_RUN;
                end
            end
            S_RUN: begin
                if (in_valid) begin
                    bit_d = bit_nxt;
                    if (inp) begin
                        if (run_nxt == thr_q) begin
                            outp_d = 1'b1;
                            run_d  = '0;
                            if (hit_q != '1) begin
                                hit_d = hit_q + HIT_W'(1);
                            end
                        end else begin
                            run_d = run_nxt;
                        end
                    end else begin
                        run_d = '0;
                    end
                    if (bit_nxt == flen_q) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_WAIT);
    assign outp    = outp_q;
    assign hit_cnt = hit_q;

endmodule

// File: tb/tb_run_detect_ctrl.sv
// tb/tb_run_detect_ctrl.sv - scoreboard bench for run_detect_ctrl
module tb_run_detect_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] run_len;
    logic [7:0] frame_len;
    logic       inp;
    logic       in_valid;
    logic       ack;
    logic       busy;
    logic       outp;
    logic [3:0] hit_cnt;
    logic       done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int mthr, mflen, mbit, mrun, mhits;
    int exp_q[$];

    run_detect_ctrl #(.CNT_W(4), .FRAME_W(8), .HIT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .run_len   (run_len),
        .frame_len (frame_len),
        .inp       (inp),
        .in_valid  (in_valid),
        .ack       (ack),
        .busy      (busy),
        .outp      (outp),
        .hit_cnt   (hit_cnt),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Every outp pulse must match the cycle the model predicted for it
    always @(negedge clk) begin
        if (rst && outp) begin
            if (exp_q.size() == 0) check("outp_spurious", 1, 0);
            else check("outp_cycle", cyc, exp_q.pop_front());
        end
    end

    task automatic start_frame(input int rl, input int fl);
        run_len   = 4'(rl);
        frame_len = 8'(fl);
        start     = 1'b1;
        mthr  = (rl == 0) ? 1 : rl;
        mflen = fl;
        mbit  = 0;
        mrun  = 0;
        mhits = 0;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_start", busy, 1);
        if (fl == 0) begin
            check("done_f0", done, 1);
            check("hit_f0", hit_cnt, 0);
        end
    endtask

    task automatic send_bit(input logic b, input int gaps);
        inp      = b;
        in_valid = 1'b1;
        mbit++;
        if (b) begin
            if (mrun + 1 == mthr) begin
                mrun = 0;
                if (mhits < 15) mhits++;
                exp_q.push_back(cyc + 1);
            end else begin
                mrun++;
            end
        end else begin
            mrun = 0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        inp      = 1'b0;
        if (mbit == mflen) begin
            check("done_rise", done, 1);
        end else begin
            check("busy_run", busy, 1);
            check("done_low", done, 0);
        end
        for (int g = 0; g < gaps; g++) begin
            @(posedge clk); #1;
            check("outp_gap", outp, 0);
            check("busy_gap", busy, 1);
        end
    endtask

    task automatic finish_frame();
        @(negedge clk); #1;
        check("done_hold", done, 1);
        check("hit_cnt", hit_cnt, mhits);
        check("pending_hits", exp_q.size(), 0);
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        check("done_ack", done, 0);
        check("busy_ack", busy, 0);
        check("hit_keep", hit_cnt, mhits);
    endtask

    logic [7:0] pat1;
    logic [3:0] pat3;

    initial begin
        rst = 1'b0; start = 1'b0; run_len = '0; frame_len = '0;
        inp = 1'b0; in_valid = 1'b0; ack = 1'b0;
        pat1 = 8'b1011_1111;
        pat3 = 4'b1101;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_outp", outp, 0);
        check("rst_hit", hit_cnt, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", busy, 0);

        // thr=3, back-to-back bits 1,1,1,1,1,1,0,1
        start_frame(3, 8);
        for (int i = 0; i < 8; i++) send_bit(pat1[i], 0);
        finish_frame();

        // same stream with two idle cycles between bits
        start_frame(3, 8);
        for (int i = 0; i < 8; i++) send_bit(pat1[i], (i < 7) ? 2 : 0);
        finish_frame();

        // run_len=0 behaves as 1; bits 1,0,1,1
        start_frame(0, 4);
        for (int i = 0; i < 4; i++) send_bit(pat3[i], 0);
        finish_frame();

        // saturation: 20 hits into a 4-bit counter
        start_frame(1, 20);
        for (int i = 0; i < 20; i++) send_bit(1'b1, 0);
        finish_frame();
        check("hit_sat", hit_cnt, 15);

        // empty frame; start together with ack must be ignored
        start_frame(5, 0);
        ack = 1'b1; start = 1'b1; frame_len = 8'd2;
        @(posedge clk); #1;
        ack = 1'b0; start = 1'b0;
        check("f0_idle_busy", busy, 0);
        check("f0_idle_done", done, 0);
        @(posedge clk); #1;
        check("start_ignored", busy, 0);
        start_frame(2, 2);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        finish_frame();

        // start during RUN ignored, then async reset mid-frame
        start_frame(2, 10);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        run_len = 4'd1; frame_len = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("run_start_busy", busy, 1);
        check("run_start_done", done, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        @(negedge clk); #1;
        check("pre_rst_hit", hit_cnt, 2);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_outp", outp, 0);
        check("mid_rst_hit", hit_cnt, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", busy, 0);
        start_frame(3, 3);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
        finish_frame();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
